rgb_frame_rx: RTL and testbench
===============================

RGB_FRAME_RX -- requirements
Module: rgb_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 100, clock cycles per serial bit (min 4).
REQ-002 SHALL have parameter NUM_PIX, default 4, number of RGB pixels buffered (1..16).
REQ-003 SHALL have parameter IDLE_BITS, default 10, number of consecutive high bit periods required to re-arm after a frame.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  1  asynchronous serial line, idles high.
REQ-007 finished  output  1  one-cycle pulse when a frame is committed.
REQ-008 frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-009 cmd_data_out, length_data_out, check_data_out  output  8 each  committed frame fields.
REQ-010 rgb_data_out  output  24*NUM_PIX  committed pixels; pixel p at [24p+23:24p], R in the high byte, then G, then B.
REQ-011 state  output  4  current FSM state encoding.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 data_in SHALL pass through a 2-flop synchroniser that resets to 1 before any use.
REQ-014 Frame SHALL be: start bit 0, then cmd, length, length payload bytes and check byte, sent back-to-back with no per-byte framing; each byte is LSB first.
REQ-015 States and encodings SHALL be IDLE=0, START=1, CMD=2, LEN=3, PAYLOAD=4, CHECK=5, DONE=6, ERR=7, WAIT_IDLE=8.
REQ-016 IDLE->START SHALL occur on the first synchronised low sample.
REQ-017 START SHALL resample the line at CLKS_PER_BIT/2 cycles; if high, it SHALL treat this as a false start and return to IDLE with no error pulse; if low, it SHALL go to CMD.
REQ-018 Data bits SHALL be sampled every CLKS_PER_BIT cycles after the start-bit mid-sample.
REQ-019 On entry to LEN completion, length SHALL be valid only if nonzero, a multiple of 3 and <=3*NUM_PIX; otherwise the FSM SHALL go to ERR.
REQ-020 Payload byte k SHALL be written to a shadow buffer at pixel k/3, component k%3 (0=R, 1=G, 2=B).
REQ-021 Running checksum SHALL be the 8-bit XOR of cmd, length and all payload bytes.
REQ-022 After the 8th check bit, the FSM SHALL go to DONE, or to ERR on mismatch when checksum is enabled.
REQ-023 DONE SHALL last one cycle: it pulses finished and copies cmd, length, check and the shadow pixels covered by length to the outputs in that same cycle; uncovered pixels retain their previous values.
REQ-024 ERR SHALL last one cycle: it pulses frame_err and leaves all data outputs unchanged.
REQ-025 DONE and ERR SHALL both go to WAIT_IDLE, which returns to IDLE only after IDLE_BITS*CLKS_PER_BIT consecutive high samples; any low sample SHALL restart that count.
REQ-026 Outputs SHALL be registered; finished SHALL assert exactly 1 cycle after the final check-bit sample.
REQ-027 finished and frame_err SHALL never assert in the same cycle.

Reset
REQ-028 Reset SHALL force state=IDLE, clear all counters and the shadow buffer, set the synchroniser to 1, and drive finished, frame_err and busy to 0, all data outputs to 0x00 and rgb_data_out to all zeros.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no finished or frame_err pulse; reception SHALL restart from IDLE after release.

Configuration
REQ-030 With RGB_RX_CHECKSUM_EN defined, a check-byte mismatch SHALL route to ERR; without it, the check byte SHALL be received and output but never compared, so every length-valid frame commits.

Verification
REQ-031 CLKS_PER_BIT=100: frame cmd 0x6D, len 0x03, payload D5/53/82, check 0x6A -> one finished pulse; pixel0 = 0xD55382, cmd 0x6D.
REQ-032 Same frame with check 0x55 -> frame_err pulse and outputs unchanged with RGB_RX_CHECKSUM_EN; with the macro undefined -> commit with check_data_out 0x55.
REQ-033 len 0x04, then len 0x00, then len 3*NUM_PIX+3 -> frame_err after the LEN byte each time; no pixel change.
REQ-034 30-cycle low glitch on idle line -> return to IDLE and no pulse; a valid frame afterwards commits.
REQ-035 Full frame of len 0x0C then a len 0x03 frame -> pixels 1..3 keep their first-frame values and only pixel0 updates.
REQ-036 Reset pulse during PAYLOAD -> all outputs 0; a clean frame sent after IDLE_BITS idle commits correctly.

Source files
------------

// File: rtl/rgb_frame_rx.sv
// Serial RGB frame receiver: start bit, cmd, length, payload and check bytes (LSB first, no per-byte framing).
// Optional checksum compare is enabled by defining RGB_RX_CHECKSUM_EN.
module rgb_frame_rx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int NUM_PIX      = 4,
  parameter int IDLE_BITS    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_in,
  output logic                    finished,
  output logic                    frame_err,
  output logic [7:0]              cmd_data_out,
  output logic [7:0]              length_data_out,
  output logic [7:0]              check_data_out,
  output logic [24*NUM_PIX-1:0]   rgb_data_out,
  output logic [3:0]              state,
  output logic                    busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_CMD       = 4'd2;
  localparam logic [3:0] S_LEN       = 4'd3;
  localparam logic [3:0] S_PAYLOAD   = 4'd4;
  localparam logic [3:0] S_CHECK     = 4'd5;
  localparam logic [3:0] S_DONE      = 4'd6;
  localparam logic [3:0] S_ERR       = 4'd7;
  localparam logic [3:0] S_WAIT_IDLE = 4'd8;

  localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int MAX_COUNT   = (IDLE_CYCLES > CLKS_PER_BIT) ? IDLE_CYCLES : CLKS_PER_BIT;
  localparam int CW          = $clog2(MAX_COUNT + 1);
  localparam int PW          = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN   = 8'(3 * NUM_PIX);

  logic          rx_meta;
  logic          rx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    shreg;
  logic [7:0]    cmd_reg;
  logic [7:0]    len_reg;
  logic [7:0]    csum;
  logic [7:0]    byte_cnt;
  logic [PW-1:0] pix_idx;
  logic [1:0]    comp;
  logic [23:0]   shadow [NUM_PIX];

  logic [7:0]    new_byte;
  logic          len_ok;
  logic          csum_bad;

  // Bits arrive LSB first, so the byte completes with the current sample on top.
  assign new_byte = {rx, shreg};
  assign len_ok   = (new_byte != 8'd0) && ((new_byte % 8'd3) == 8'd0) && (new_byte <= MAX_LEN);

`ifdef RGB_RX_CHECKSUM_EN
  assign csum_bad = (new_byte != csum);
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta         <= 1'b1;
      rx              <= 1'b1;
      state           <= S_IDLE;
      busy            <= 1'b0;
      finished        <= 1'b0;
      frame_err       <= 1'b0;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      cmd_reg         <= '0;
      len_reg         <= '0;
      csum            <= '0;
      byte_cnt        <= '0;
      pix_idx         <= '0;
      comp            <= '0;
      cmd_data_out    <= '0;
      length_data_out <= '0;
      check_data_out  <= '0;
      rgb_data_out    <= '0;
      // NOTE: the shadow buffer is reset explicitly so a reset can never leak stale pixels.
      for (int p = 0; p < NUM_PIX; p++) shadow[p] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
      rx_meta <= data_in;
      rx      <= rx_meta;

      case (state)
        S_IDLE: begin
          if (!rx) begin
            state <= S_START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_CMD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_CMD, S_LEN, S_PAYLOAD, S_CHECK: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= new_byte[7:1];
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              case (state)
                S_CMD: begin
                  cmd_reg <= new_byte;
                  csum    <= new_byte;
                  state   <= S_LEN;
                end
                S_LEN: begin
                  len_reg  <= new_byte;
                  csum     <= csum ^ new_byte;
                  byte_cnt <= '0;
                  pix_idx  <= '0;
                  comp     <= '0;
                  if (len_ok) begin
                    state <= S_PAYLOAD;
                  end else begin
                    state     <= S_ERR;
                    frame_err <= 1'b1;
                  end
                end
                S_PAYLOAD: begin
                  case (comp)
                    2'd0:    shadow[pix_idx][23:16] <= new_byte;
                    2'd1:    shadow[pix_idx][15:8]  <= new_byte;
                    default: shadow[pix_idx][7:0]   <= new_byte;
                  endcase
                  if (comp == 2'd2) begin
                    comp    <= 2'd0;
                    pix_idx <= pix_idx + PW'(1);
                  end else begin
                    comp <= comp + 2'd1;
                  end
                  csum     <= csum ^ new_byte;
                  byte_cnt <= byte_cnt + 8'd1;
                  if (byte_cnt == len_reg - 8'd1) state <= S_CHECK;
                end
                default: begin
                  if (csum_bad) begin
                    state     <= S_ERR;
                    frame_err <= 1'b1;
                  end else begin
                    // Commit lands on the DONE cycle together with the finished pulse.
                    state           <= S_DONE;
                    finished        <= 1'b1;
                    cmd_data_out    <= cmd_reg;
                    length_data_out <= len_reg;
                    check_data_out  <= new_byte;
                    for (int p = 0; p < NUM_PIX; p++) begin
                      if (3 * p < int'(len_reg)) rgb_data_out[24*p +: 24] <= shadow[p];
                    end
                  end
                end
              endcase
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE, S_ERR: begin
          finished  <= 1'b0;
          frame_err <= 1'b0;
          state     <= S_WAIT_IDLE;
          cnt       <= '0;
        end

        S_WAIT_IDLE: begin
          if (!rx) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_frame_rx.sv
// Self-checking bench for rgb_frame_rx: table of frames, corner-case sequences and random frames
// compared against a frame-level reference model.
module tb_rgb_frame_rx;

  localparam int CPB = 100;
  localparam int NP  = 4;
  localparam int IB  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              data_in;
  logic              finished;
  logic              frame_err;
  logic [7:0]        cmd_data_out;
  logic [7:0]        length_data_out;
  logic [7:0]        check_data_out;
  logic [24*NP-1:0]  rgb_data_out;
  logic [3:0]        state;
  logic              busy;

  rgb_frame_rx #(.CLKS_PER_BIT(CPB), .NUM_PIX(NP), .IDLE_BITS(IB)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .finished        (finished),
    .frame_err       (frame_err),
    .cmd_data_out    (cmd_data_out),
    .length_data_out (length_data_out),
    .check_data_out  (check_data_out),
    .rgb_data_out    (rgb_data_out),
    .state           (state),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [95:0] pay;      // byte k at [8k+7:8k]
    logic [7:0]  chk;
    int          npay;     // payload bytes actually transmitted
    bit          send_chk;
    bit          exp_ok;   // 1: commit expected, 0: frame_err expected
  } vec_t;

  int total = 0;
  int bad   = 0;

  int fin_cnt = 0, err_cnt = 0, both_cnt = 0, cyc = 0, fin_cycle = 0;

  logic [23:0] m_pix [NP];
  logic [7:0]  m_cmd, m_len, m_chk;

  vec_t tbl [8];

  always @(negedge clk) begin
    cyc++;
    if (finished) begin
      fin_cnt++;
      fin_cycle = cyc;
    end
    if (frame_err) err_cnt++;
    if (finished && frame_err) both_cnt++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] c, input logic [7:0] l,
                                      input logic [95:0] p, input int n);
    logic [7:0] x;
    x = c ^ l;
    for (int k = 0; k < n; k++) x ^= p[8*k +: 8];
    return x;
  endfunction

  function automatic bit model_ok(input vec_t v);
    bit valid;
    valid = (v.len != 0) && (v.len % 3 == 0) && (int'(v.len) <= 3 * NP);
`ifdef RGB_RX_CHECKSUM_EN
    return valid && (v.chk == xsum(v.cmd, v.len, v.pay, int'(v.len)));
`else
    return valid;
`endif
  endfunction

  function automatic logic [24*NP-1:0] model_rgb();
    logic [24*NP-1:0] r;
    for (int p = 0; p < NP; p++) r[24*p +: 24] = m_pix[p];
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_pix[p] = '0;
    m_cmd = '0; m_len = '0; m_chk = '0;
  endtask

  task automatic model_commit(input vec_t v);
    for (int k = 0; k < int'(v.len); k++) m_pix[k/3][23 - 8*(k%3) -: 8] = v.pay[8*k +: 8];
    m_cmd = v.cmd; m_len = v.len; m_chk = v.chk;
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (state != 4'd0 && n < IB*CPB + 4*CPB) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, state, 4'd0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_cmd"}, cmd_data_out, m_cmd);
    check({tag, "_len"}, length_data_out, m_len);
    check({tag, "_chk"}, check_data_out, m_chk);
    check({tag, "_rgb"}, rgb_data_out, model_rgb());
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int f0, e0, t_last;
    f0 = fin_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    send_byte(v.cmd);
    if (!v.send_chk && v.npay == 0) begin
      for (int i = 0; i < 7; i++) send_bit(v.len[i]);
      t_last = cyc;
      send_bit(v.len[7]);
    end else begin
      send_byte(v.len);
      for (int k = 0; k < v.npay; k++) send_byte(v.pay[8*k +: 8]);
      for (int i = 0; i < 7; i++) send_bit(v.chk[i]);
      t_last = cyc;
      send_bit(v.chk[7]);
    end
    data_in = 1'b1;
    wait_idle(tag);
    check({tag, "_fin"}, fin_cnt - f0, v.exp_ok ? 1 : 0);
    check({tag, "_err"}, err_cnt - e0, v.exp_ok ? 0 : 1);
    if (v.exp_ok) begin
      check({tag, "_fin_lat"},
            (fin_cycle - t_last >= CPB/2 - 5) && (fin_cycle - t_last <= CPB/2 + 10), 1'b1);
      model_commit(v);
    end
    check_outputs(tag);
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic [7:0] l, input logic [95:0] p,
                              input logic [7:0] k, input int n, input bit sc, input bit ok);
    vec_t v;
    v.cmd = c; v.len = l; v.pay = p; v.chk = k; v.npay = n; v.send_chk = sc; v.exp_ok = ok;
    return v;
  endfunction

  initial begin
    logic [95:0] p12;
    logic [95:0] p3;
    vec_t        v;
    int          f0, e0;

    for (int k = 0; k < 12; k++) p12[8*k +: 8] = 8'(8'h10 + 8'h11 * k);
    p3 = {72'h0, 8'hCC, 8'hBB, 8'hAA};

    tbl[0] = mk(8'h6D, 8'h03, {72'h0, 8'h82, 8'h53, 8'hD5}, 8'h6A, 3, 1'b1, 1'b1);
`ifdef RGB_RX_CHECKSUM_EN
    tbl[1] = mk(8'h6D, 8'h03, {72'h0, 8'h82, 8'h53, 8'hD5}, 8'h55, 3, 1'b1, 1'b0);
`else
    tbl[1] = mk(8'h6D, 8'h03, {72'h0, 8'h82, 8'h53, 8'hD5}, 8'h55, 3, 1'b1, 1'b1);
`endif
    tbl[2] = mk(8'h11, 8'h04, 96'h0, 8'h00, 0, 1'b0, 1'b0);
    tbl[3] = mk(8'h22, 8'h00, 96'h0, 8'h00, 0, 1'b0, 1'b0);
    tbl[4] = mk(8'h33, 8'(3*NP+3), 96'h0, 8'h00, 0, 1'b0, 1'b0);
    tbl[5] = mk(8'hA5, 8'h0C, p12, xsum(8'hA5, 8'h0C, p12, 12), 12, 1'b1, 1'b1);
    tbl[6] = mk(8'h5A, 8'h03, p3, xsum(8'h5A, 8'h03, p3, 3), 3, 1'b1, 1'b1);
    tbl[7] = mk(8'h3C, 8'h03, {72'h0, 8'h56, 8'h34, 8'h12},
                xsum(8'h3C, 8'h03, {72'h0, 8'h56, 8'h34, 8'h12}, 3), 3, 1'b1, 1'b1);

    // Reset state
    model_reset();
    reset   = 1'b1;
    data_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_state", state, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_fin", finished, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check_outputs("rst");

    // Directed frames: good, bad check, three bad lengths, full then short frame
    for (int i = 0; i < 7; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

    // Glitch shorter than half a bit is a false start
    f0 = fin_cnt; e0 = err_cnt;
    data_in = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_busy", busy, 1'b1);
    data_in = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_state", state, 4'd0);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_pulses", (fin_cnt - f0) + (err_cnt - e0), 0);
    run_frame("after_glitch", tbl[7]);

    // Reset in the middle of PAYLOAD aborts silently
    f0 = fin_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_byte(8'h77);
    send_byte(8'h06);
    send_byte(8'h9E);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("mid_state_payload", state, 4'd4);
    reset   = 1'b1;
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check("mid_rst_state", state, 4'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pulses", (fin_cnt - f0) + (err_cnt - e0), 0);
    check_outputs("mid_rst");
    repeat (IB*CPB + 10) @(negedge clk);
    run_frame("after_rst", tbl[0]);

    // Random frames against the reference model
    for (int r = 0; r < 2; r++) begin
      v.cmd  = 8'($urandom);
      v.len  = 8'(3 * $urandom_range(1, 2));
      v.pay  = {$urandom, $urandom, $urandom};
      v.npay = int'(v.len);
      v.chk  = xsum(v.cmd, v.len, v.pay, v.npay);
      if ($urandom_range(0, 1) == 1) v.chk = v.chk ^ 8'($urandom_range(1, 255));
      v.send_chk = 1'b1;
      v.exp_ok   = model_ok(v);
      run_frame($sformatf("rand%0d", r), v);
    end

    check("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
